// File: rtl/message_scan_driver.sv
// message_scan_driver
// Time-multiplexes a fixed 16-character hex message across four common-anode
// 7-segment digits. The rotation position is captured once per frame so a
// frame never mixes two positions, and every digit slot opens with a blanking
// window (anodes and segments off) to suppress ghosting between digits.
//
// Scan phases (derived from the slot counter, no separate state register):
//   phase  | meaning
//   -------+---------------------------------------------------------------
//   blank  | cnt < BLANK_CYCLES: all anodes off, segments off
//   drive  | cnt >= BLANK_CYCLES: anode for digit d on, glyph(pos_q + d)
//   latch  | cnt == 0 && d == 0: position captured, frame_start pulsed
//            (always inside a blank window because BLANK_CYCLES >= 1)

module message_scan_driver #(
    parameter logic [15:0] DIGIT_CYCLES = 16'd50000,
    parameter logic [15:0] BLANK_CYCLES = 16'd1000
) (
    input  logic       clkdv,
    input  logic       reset,
    input  logic [3:0] counter,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    if (DIGIT_CYCLES < 16'd2) begin : g_bad_digit_cycles
        $error("DIGIT_CYCLES must be at least 2");
    end
    if ((BLANK_CYCLES < 16'd1) || (BLANK_CYCLES >= DIGIT_CYCLES)) begin : g_bad_blank_cycles
        $error("BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DIGIT_CYCLES");
    end

    localparam logic [15:0] CNT_LAST = DIGIT_CYCLES - 16'd1;
    localparam logic [3:0]  AN_OFF   = 4'b1111;
    localparam logic [6:0]  SEG_OFF  = 7'b1111111;

    // Active-low gfedcba glyphs for the message "0123456789AbCdEF".
    function automatic logic [6:0] glyph(input logic [3:0] ch);
        logic [6:0] g;
        unique case (ch)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
        endcase
        return g;
    endfunction

    logic [15:0] cnt;
    logic [1:0]  d;
    logic [3:0]  pos_q;

    logic        slot_end;
    logic        frame_edge;
    logic        in_blank;
    logic [3:0]  char_idx;
    logic [3:0]  an_next;
    logic [6:0]  seg_next;

    // Slot timing decode and the next anode/segment pattern from pre-edge state.
    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        frame_edge = (cnt == 16'd0) && (d == 2'd0);
        in_blank   = (cnt < BLANK_CYCLES);
        char_idx   = pos_q + {2'b00, d};
        an_next    = AN_OFF;
        seg_next   = SEG_OFF;
        if (!in_blank) begin
            an_next  = ~(4'b1000 >> d);
            seg_next = glyph(char_idx);
        end
    end

    // Slot counter, digit index and once-per-frame position capture.
    always_ff @(posedge clkdv or negedge reset) begin
        if (!reset) begin
            cnt         <= 16'd0;
            d           <= 2'd0;
            pos_q       <= 4'd0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= slot_end ? 16'd0 : cnt + 16'd1;
            if (slot_end) begin
                d <= d + 2'd1;
            end
            if (frame_edge) begin
                pos_q <= counter;
            end
            frame_start <= frame_edge;
        end
    end

    // Registered display drive; reset blanks the display immediately.
    always_ff @(posedge clkdv or negedge reset) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

    // Decimal point is never used by this message.
    assign dp = 1'b1;

endmodule

// File: tb/tb_message_scan_driver.sv
// Bench for message_scan_driver with short slots (8 cycles, 2 blank).
// Expected outputs come from a time-index model: each step pushes the
// expected {an,seg,dp,frame_start} for the coming edge, then pops it after
// the edge and compares against the DUT.

module tb_message_scan_driver;

    localparam int DC = 8;
    localparam int BC = 2;

    logic       clkdv;
    logic       reset;
    logic [3:0] counter;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    message_scan_driver #(
        .DIGIT_CYCLES(16'(DC)),
        .BLANK_CYCLES(16'(BC))
    ) dut (
        .clkdv      (clkdv),
        .reset      (reset),
        .counter    (counter),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    initial clkdv = 1'b0;
    always #5 clkdv = ~clkdv;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [3:0] anode_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    localparam logic [12:0] BLANK_EXP = {4'b1111, 7'b1111111, 1'b1, 1'b0};

    int          checks = 0;
    int          errors = 0;
    int          s = 0;
    int          edge_n = 0;
    int          last_fs = -1;
    int          active_len = 0;
    int          blank_len = 0;
    logic        prev_active = 1'b0;
    logic [3:0]  pos_m = 4'd0;
    logic [12:0] sb [$];

    task automatic check13(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
        end
    endtask

    // Drive one cycle: predict, push, clock, pop and compare.
    task automatic step(input logic [3:0] c);
        logic [12:0] exp;
        logic [12:0] obs;
        int          w;
        int          dd;
        logic        act;
        counter = c;
        if (!reset) begin
            exp = BLANK_EXP;
            s   = 0;
        end else begin
            w  = s % DC;
            dd = (s / DC) % 4;
            if (s % (4 * DC) == 0) pos_m = c;
            if (w < BC) exp = {4'b1111, 7'b1111111, 1'b1, (s % (4 * DC) == 0)};
            else        exp = {anode_tab[dd], glyph_tab[4'(pos_m + 4'(dd))], 1'b1, 1'b0};
            s++;
        end
        sb.push_back(exp);
        @(posedge clkdv);
        #1;
        edge_n++;
        obs = {an, seg, dp, frame_start};
        check13("outputs", obs, sb.pop_front());
        check_int("onehot_an", int'($countones(~an) <= 1), 1);
        if (!reset) begin
            last_fs     = -1;
            active_len  = 0;
            blank_len   = 0;
            prev_active = 1'b0;
        end else begin
            if (frame_start) begin
                if (last_fs >= 0) check_int("fs_period", edge_n - last_fs, 4 * DC);
                last_fs = edge_n;
            end
            act = (an != 4'b1111);
            if (act && !prev_active) begin
                check_int("blank_run", blank_len, BC);
                active_len = 0;
            end
            if (!act && prev_active) begin
                check_int("active_run", active_len, DC - BC);
                blank_len = 0;
            end
            if (act) active_len++;
            else     blank_len++;
            prev_active = act;
        end
    endtask

    initial begin
        reset   = 1'b1;
        counter = 4'h7;
        #2;
        reset = 1'b0;
        #1;
        check13("rst_async", {an, seg, dp, frame_start}, BLANK_EXP);
        repeat (5) step(4'h7);

        reset = 1'b1;
        repeat (32) step(4'h0);
        repeat (32) step(4'hE);
        repeat (20) step(4'h3);
        repeat (44) step(4'h4);

        repeat (20) step(4'h4);
        reset = 1'b0;
        #1;
        check13("rst_mid_slot", {an, seg, dp, frame_start}, BLANK_EXP);
        repeat (3) step(4'h4);
        reset = 1'b1;
        repeat (40) step(4'h9);

        repeat (1000) step(4'($urandom_range(0, 15)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/message_scan_driver.md
Name: message_scan_driver

Overview:
Consumer side of the rotating-message display path. Takes the 4-bit rotation position from the time counter and time-multiplexes a fixed 16-character message across four common-anode 7-segment digits. The rotation position is sampled only at frame boundaries so that a single frame never shows two different positions. Each digit slot begins with a blanking window, with anodes off, to suppress ghosting.

Parameters:
DIGIT_CYCLES, 16'd50000, clkdv cycles per digit slot, including blanking; legal range 2..65535.
BLANK_CYCLES, 16'd1000, cycles at the start of each slot with anodes and segments off; must satisfy 1 <= BLANK_CYCLES < DIGIT_CYCLES.

Ports:
clkdv  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low; asserted when 0.
counter  input  4  rotation position from the time counter; synchronous to clkdv.
an  output  4  anode enables, active-low; an[3] is the leftmost digit.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low; held at 1 (off).
frame_start  output  1  one-cycle pulse each time the position is latched.

Behaviour:
- Reset (reset=0), applied immediately and asynchronously:
  - an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
  - Internal registers: slot counter cnt=0, digit index d=0, latched position pos_q=0.
- State per clkdv edge, with all values taken before the edge:
  - cnt <= (cnt==DIGIT_CYCLES-1) ? 0 : cnt+1.
  - d <= d+1 (2-bit, wraps 3->0) only when cnt==DIGIT_CYCLES-1.
  - When cnt==0 && d==0: pos_q <= counter and frame_start <= 1. Otherwise frame_start <= 0.
- Registered outputs, computed from pre-edge cnt, d and pos_q:
  - cnt < BLANK_CYCLES: an <= 4'b1111, seg <= 7'b1111111.
  - Otherwise: an <= ~(4'b1000 >> d), seg <= glyph(pos_q + d).
  - pos_q + d is a 4-bit add that wraps modulo 16.
- Latching at cnt==0 falls inside the blanking window (BLANK_CYCLES >= 1), so a stale pos_q is never driven.
- Digit mapping: d=0 drives an[3] with char pos+0, through d=3 driving an[0] with char pos+3.
- Message ROM: char i = hex value i, i.e. "0123456789AbCdEF".
- Glyphs, active-low gfedcba:
  - 0=1000000 1=1111001 2=0100100 3=0110000
  - 4=0011001 5=0010010 6=0000010 7=1111000
  - 8=0000000 9=0010000 A=0001000 b=0000011
  - C=1000110 d=0100001 E=0000110 F=0001110
- Per slot: anodes off for exactly BLANK_CYCLES cycles, then one anode on for exactly DIGIT_CYCLES-BLANK_CYCLES cycles.
- Frame period is 4*DIGIT_CYCLES cycles; frame_start pulses once per frame.
- Changes on counter between latch points are ignored until the next frame start.
- At most one anode is low in any cycle; there is no overlap at slot boundaries.
- The first frame after reset release starts at cnt=0, d=0. The first frame_start occurs at the first edge and latches counter.
- Reset asserted mid-slot: outputs blank at once. On release the scan restarts from d=0 with blanking, and no partial slot is resumed.

Test Plan:
- Hold reset=0 for 5 cycles with counter=4'h7 -> an=1111, seg=1111111, dp=1, frame_start=0 throughout.
- DIGIT_CYCLES=8, BLANK_CYCLES=2, counter=0, release reset:
  - First slot: an=1111 for 2 cycles, then an=0111 with seg=1000000 for 6 cycles.
  - Next slot: an=1011 with seg=1111001.
  - Then an=1101 with '2' and an=1110 with '3'.
- counter=4'hE -> digits left to right show E,F,0,1: seg 0000110, 0001110, 1000000, 1111001 (wrap-around check).
- counter changes 3->4 while d=2 -> current frame still shows 3,4,5,6; next frame shows 4,5,6,7; frame_start pulses exactly 32 cycles apart.
- Pull reset low during d=2 drive and release after 3 cycles -> outputs blank immediately; the scan restarts at an[3] after 2 blank cycles; frame_start pulses on the first post-release edge.
- Monitor 1000 cycles with counter randomised -> never more than one an bit low; every anode-on run is exactly 6 cycles, preceded by 2 all-off cycles.
